// File: rtl/da_ctrl.sv
// Sequencing controller for the distributed-arithmetic FIR datapath: streams the
// coefficient set into the DA ROMs, runs the 12x16 compute schedule and hands off results.
module da_ctrl #(
    parameter int ROM_WORDS    = 2048,
    parameter int ADDR_W       = 11,
    parameter int COEF_W       = 20,
    parameter int ACC_W        = 39,
    parameter int FRAME_CYCLES = 12,
    parameter int FRAMES       = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_req,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              load_done,
    output logic              loaded,
    input  logic              run_en,
    output logic              busy,
    output logic [ADDR_W-1:0] da_caddr,
    output logic [COEF_W-1:0] da_cin,
    output logic              da_cload,
    output logic              da_valid_in,
    output logic              da_start,
    output logic              da_reset,
    output logic              smp_en,
    input  logic [ACC_W-1:0]  da_acc_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              overrun
);

    localparam int CYC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int FRM_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_WORDS - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(FRAME_CYCLES - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(FRAMES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);
    localparam logic [FRM_W-1:0]  FRM_ONE   = FRM_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [CYC_W-1:0]   cyc_r;
    logic [FRM_W-1:0]   frm_r;

    logic               beat_s;
    logic               last_beat_s;
    logic               grp_end_s;
    logic               accept_s;
    logic [CYC_W-1:0]   cyc_nxt_s;
    logic [FRM_W-1:0]   frm_nxt_s;

    // Handshake, schedule-position and next-counter decode.
    always_comb begin
        beat_s      = (state_r == ST_LOAD) && cfg_valid && cfg_ready;
        last_beat_s = beat_s && (addr_r == LAST_ADDR);
        grp_end_s   = (state_r == ST_RUN) && (cyc_r == CYC_LAST) && (frm_r == FRM_LAST);
        accept_s    = res_valid && res_ready;
        if (cyc_r == CYC_LAST) begin
            cyc_nxt_s = '0;
            if (frm_r == FRM_LAST) begin
                frm_nxt_s = '0;
            end else begin
                frm_nxt_s = frm_r + FRM_ONE;
            end
        end else begin
            cyc_nxt_s = cyc_r + CYC_ONE;
            frm_nxt_s = frm_r;
        end
    end

    // Control FSM with all DA-side and config-side outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            cyc_r       <= '0;
            frm_r       <= '0;
            cfg_ready   <= 1'b0;
            load_done   <= 1'b0;
            loaded      <= 1'b0;
            busy        <= 1'b0;
            da_caddr    <= '0;
            da_cin      <= '0;
            da_cload    <= 1'b0;
            da_valid_in <= 1'b0;
            da_start    <= 1'b0;
            da_reset    <= 1'b0;
            smp_en      <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to 0 unless a branch below re-asserts them.
            load_done   <= 1'b0;
            da_cin      <= '0;
            da_cload    <= 1'b0;
            da_valid_in <= 1'b0;
            da_start    <= 1'b0;
            da_reset    <= 1'b0;
            smp_en      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load_req) begin
                        state_r   <= ST_LOAD;
                        addr_r    <= '0;
                        loaded    <= 1'b0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end else if (run_en && loaded) begin
                        state_r   <= ST_RUN;
                        cyc_r     <= '0;
                        frm_r     <= '0;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        da_start  <= 1'b1;
                        da_reset  <= 1'b1;
                        smp_en    <= 1'b1;
                    end else begin
                        cfg_ready <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (beat_s) begin
                        da_caddr    <= addr_r;
                        da_cin      <= cfg_data;
                        da_cload    <= 1'b1;
                        da_valid_in <= 1'b1;
                        if (last_beat_s) begin
                            // The address stays parked on the last word: no wrap into ROM 0.
                            state_r   <= ST_IDLE;
                            cfg_ready <= 1'b0;
                            load_done <= 1'b1;
                            loaded    <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            addr_r    <= addr_r + ADDR_ONE;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end else begin
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cfg_ready <= 1'b0;
                    if (grp_end_s && !run_en) begin
                        state_r <= ST_IDLE;
                        cyc_r   <= '0;
                        frm_r   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        cyc_r    <= cyc_nxt_s;
                        frm_r    <= frm_nxt_s;
                        busy     <= 1'b1;
                        smp_en   <= 1'b1;
                        da_start <= (cyc_nxt_s == '0);
                        da_reset <= (cyc_nxt_s == '0) && (frm_nxt_s == '0);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    addr_r    <= '0;
                    cyc_r     <= '0;
                    frm_r     <= '0;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Result holding register with sticky overrun on an unaccepted overwrite.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (grp_end_s) begin
                res_data  <= da_acc_out;
                res_valid <= 1'b1;
                if (res_valid && !res_ready) begin
                    overrun <= 1'b1;
                end else begin
                    overrun <= overrun;
                end
            end else if (accept_s) begin
                res_valid <= 1'b0;
            end else begin
                res_valid <= res_valid;
            end
        end
    end

endmodule

// File: tb/tb_da_ctrl.sv
// Directed bench for da_ctrl: coefficient load, reset during load, compute
// schedule, result handshake, overrun and run stop.
module tb_da_ctrl;

    localparam int ROM_WORDS = 2048;
    localparam logic [38:0] ACC_M5 = 39'h7F_FFFF_FFFB;
    localparam logic [38:0] V2     = 39'h00_0000_1234;
    localparam logic [38:0] V3     = 39'h40_0000_0001;
    localparam logic [38:0] V4     = 39'h3F_FFFF_FFFF;
    localparam logic [38:0] V5     = 39'h7F_8000_0000;
    localparam logic [38:0] JUNK   = 39'h55_0000_AAAA;

    logic        clk;
    logic        resetn;
    logic        load_req;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [19:0] cfg_data;
    logic        load_done;
    logic        loaded;
    logic        run_en;
    logic        busy;
    logic [10:0] da_caddr;
    logic [19:0] da_cin;
    logic        da_cload;
    logic        da_valid_in;
    logic        da_start;
    logic        da_reset;
    logic        smp_en;
    logic [38:0] da_acc_out;
    logic        res_valid;
    logic        res_ready;
    logic [38:0] res_data;
    logic        overrun;

    int n_asserts = 0;
    int n_fail    = 0;

    da_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .load_req    (load_req),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .load_done   (load_done),
        .loaded      (loaded),
        .run_en      (run_en),
        .busy        (busy),
        .da_caddr    (da_caddr),
        .da_cin      (da_cin),
        .da_cload    (da_cload),
        .da_valid_in (da_valid_in),
        .da_start    (da_start),
        .da_reset    (da_reset),
        .smp_en      (smp_en),
        .da_acc_out  (da_acc_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] coef(input int i);
        coef = 20'(i * 613) ^ 20'h8_1234;
    endfunction

    task automatic check_all_zero(input string tag);
        chk1({tag, "_cfg_ready"}, cfg_ready, 1'b0);
        chk1({tag, "_load_done"}, load_done, 1'b0);
        chk1({tag, "_loaded"}, loaded, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chkw({tag, "_caddr"}, 64'(da_caddr), 64'd0);
        chkw({tag, "_cin"}, 64'(da_cin), 64'd0);
        chk1({tag, "_cload"}, da_cload, 1'b0);
        chk1({tag, "_valid_in"}, da_valid_in, 1'b0);
        chk1({tag, "_start"}, da_start, 1'b0);
        chk1({tag, "_reset"}, da_reset, 1'b0);
        chk1({tag, "_smp_en"}, smp_en, 1'b0);
        chk1({tag, "_res_valid"}, res_valid, 1'b0);
        chkw({tag, "_res_data"}, 64'(res_data), 64'd0);
        chk1({tag, "_overrun"}, overrun, 1'b0);
    endtask

    task automatic do_load(input int nbeats, input bit toggle);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        run_en   = 1'b0;
        chk1("load_entry_ready", cfg_ready, 1'b1);
        chk1("load_entry_busy", busy, 1'b1);
        chk1("load_entry_loaded_clr", loaded, 1'b0);
        chk1("load_wins_no_start", da_start, 1'b0);
        for (int i = 0; i < nbeats; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = coef(i);
            step();
            chk1("beat_cload", da_cload, 1'b1);
            chk1("beat_valid_in", da_valid_in, 1'b1);
            chkw("beat_caddr", 64'(da_caddr), 64'(i));
            chkw("beat_cin", 64'(da_cin), 64'(coef(i)));
            if (i == ROM_WORDS - 1) begin
                chk1("last_load_done", load_done, 1'b1);
                chk1("last_ready_low", cfg_ready, 1'b0);
                chk1("last_loaded", loaded, 1'b1);
                chk1("last_busy_low", busy, 1'b0);
            end else begin
                chk1("mid_load_done", load_done, 1'b0);
                chk1("mid_ready", cfg_ready, 1'b1);
            end
            if (toggle) begin
                cfg_valid = 1'b0;
                cfg_data  = 20'hF_FFFF;
                step();
                chk1("gap_cload", da_cload, 1'b0);
                chk1("gap_valid_in", da_valid_in, 1'b0);
                chkw("gap_cin", 64'(da_cin), 64'd0);
                chkw("gap_caddr_hold", 64'(da_caddr), 64'(i));
                chk1("gap_load_done", load_done, 1'b0);
            end
        end
    endtask

    initial begin
        resetn     = 1'b0;
        load_req   = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = 20'h0_0000;
        run_en     = 1'b0;
        da_acc_out = JUNK;
        res_ready  = 1'b0;
        step();
        step();
        check_all_zero("rst");

        resetn = 1'b1;
        step();
        chk1("idle_no_run_unloaded", busy, 1'b0);

        // Partial load, then asynchronous reset in the middle of a cycle.
        do_load(700, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("midload_rst");
        step();
        resetn    = 1'b1;
        cfg_valid = 1'b0;
        step();

        do_load(ROM_WORDS, 1'b0);
        cfg_valid = 1'b1;
        cfg_data  = 20'hA_BCDE;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("post_cload", da_cload, 1'b0);
            chk1("post_ready", cfg_ready, 1'b0);
            chk1("post_load_done", load_done, 1'b0);
            chkw("post_caddr", 64'(da_caddr), 64'd2047);
        end
        cfg_valid = 1'b0;

        // load_req and run_en together: load wins; beats every other cycle.
        run_en = 1'b1;
        do_load(ROM_WORDS, 1'b1);
        step();
        chk1("idle_after_load_start", da_start, 1'b0);
        chk1("idle_after_load_busy", busy, 1'b0);
        chk1("idle_after_load_loaded", loaded, 1'b1);

        run_en = 1'b1;
        step();
        for (int t = 0; t <= 961; t++) begin
            if (t < 960) begin
                chk1("run_start", da_start, (t % 12) == 0);
                chk1("run_reset", da_reset, (t % 192) == 0);
                chk1("run_smp_en", smp_en, 1'b1);
                chk1("run_busy", busy, 1'b1);
                chk1("run_cload", da_cload, 1'b0);
                chk1("run_valid_in", da_valid_in, 1'b0);
            end
            if (t == 191) chk1("rv_before_first", res_valid, 1'b0);
            if (t == 192) begin
                chk1("rv1", res_valid, 1'b1);
                chkw("rd1_minus5", 64'(res_data), 64'(ACC_M5));
                chk1("ov1", overrun, 1'b0);
            end
            if (t == 193) chk1("rv1_accepted", res_valid, 1'b0);
            if (t == 384) begin
                chk1("rv2", res_valid, 1'b1);
                chkw("rd2", 64'(res_data), 64'(V2));
                chk1("ov2", overrun, 1'b0);
            end
            if (t == 500) chk1("rv2_held", res_valid, 1'b1);
            if (t == 576) begin
                chk1("rv3_acc_and_cap", res_valid, 1'b1);
                chkw("rd3", 64'(res_data), 64'(V3));
                chk1("ov3_stays_0", overrun, 1'b0);
            end
            if (t == 768) begin
                chk1("rv4", res_valid, 1'b1);
                chkw("rd4_overwrite", 64'(res_data), 64'(V4));
                chk1("ov4_set", overrun, 1'b1);
            end
            if (t == 769) chk1("rv4_accepted", res_valid, 1'b0);
            if (t == 901) begin
                chk1("run_load_req_ign_ready", cfg_ready, 1'b0);
                chk1("run_load_req_ign_loaded", loaded, 1'b1);
            end
            if (t == 960) begin
                chk1("rv5", res_valid, 1'b1);
                chkw("rd5", 64'(res_data), 64'(V5));
                chk1("stop_busy", busy, 1'b0);
                chk1("stop_smp_en", smp_en, 1'b0);
                chk1("stop_start", da_start, 1'b0);
            end
            if (t == 961) begin
                chk1("rv5_accepted", res_valid, 1'b0);
                chk1("stop_idle_busy", busy, 1'b0);
            end

            res_ready  = (t <= 192) || (t == 575) || (t >= 768);
            run_en     = (t < 828);
            load_req   = (t == 900);
            case (t)
                191:     da_acc_out = ACC_M5;
                383:     da_acc_out = V2;
                575:     da_acc_out = V3;
                767:     da_acc_out = V4;
                959:     da_acc_out = V5;
                default: da_acc_out = JUNK;
            endcase
            step();
        end

        for (int k = 0; k < 4; k++) begin
            step();
            chk1("idle_tail_start", da_start, 1'b0);
            chk1("idle_tail_busy", busy, 1'b0);
        end
        chk1("overrun_sticky", overrun, 1'b1);
        chk1("loaded_kept", loaded, 1'b1);

        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("final_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/da_ctrl.md
Name: da_ctrl

Overview:
- Sequencing controller for the `da` distributed-arithmetic FIR datapath.
- Streams 2048 precomputed 20-bit coefficients into the datapath's eight 256-entry ROMs, then runs the compute schedule: 12-cycle frames, 16 frames per output.
- Captures the 39-bit accumulator at the end of each 16-frame group and presents it on a valid/ready result port.
- Sits between the system bus/config logic and `da`.

Parameters:
- ROM_WORDS, 2048, total coefficient words (8 ROMs x 256).
- ADDR_W, 11, coefficient address width; bits [10:8] select the ROM, bits [7:0] the entry.
- COEF_W, 20, coefficient width (signed).
- ACC_W, 39, accumulator/result width.
- FRAME_CYCLES, 12, cycles per frame; start is issued on cycle 0.
- FRAMES, 16, frames per output result.

Ports:
- clk  in  1  single clock, rising-edge.
- resetn  in  1  asynchronous active-low reset.
- load_req  in  1  pulse: begin coefficient load; honoured only in IDLE.
- cfg_valid  in  1  coefficient beat valid.
- cfg_ready  out  1  controller accepts a coefficient beat.
- cfg_data  in  COEF_W  coefficient value.
- load_done  out  1  one-cycle pulse after the last beat is issued.
- loaded  out  1  sticky: the ROMs hold a complete coefficient set.
- run_en  in  1  level: request continuous computation.
- busy  out  1  high in LOAD or RUN.
- da_caddr  out  ADDR_W  to DA CADDR.
- da_cin  out  COEF_W  to DA CIN.
- da_cload  out  1  to DA CLOAD.
- da_valid_in  out  1  to DA valid_in.
- da_start  out  1  to DA start.
- da_reset  out  1  to DA reset (accumulator clear).
- smp_en  out  1  tells the sample source to present A7..A0 this cycle.
- da_acc_out  in  ACC_W  from DA ACC_OUT.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  ACC_W  captured accumulator (signed).
- overrun  out  1  sticky: a result was overwritten before it was accepted.

Behaviour:
- Reset state (resetn low, asynchronous): all outputs 0, state IDLE, all counters 0, loaded=0, overrun=0.
- All outputs are registered.
- IDLE:
  - load_req → LOAD, address counter = 0, loaded cleared.
  - Otherwise, run_en && loaded → RUN with cyc=0, frm=0.
  - If both are asserted in the same cycle, load_req wins.
  - load_req is ignored in LOAD and RUN.
- LOAD:
  - cfg_ready=1.
  - Each handshake (cfg_valid && cfg_ready) registers da_caddr=addr, da_cin=cfg_data, da_cload=1, da_valid_in=1 on the next cycle, then addr+1.
  - With no handshake, da_cload, da_valid_in and da_cin drop to 0; da_caddr holds its value.
  - On the handshake at addr=ROM_WORDS-1: cfg_ready falls in the following cycle, load_done pulses that cycle, loaded=1, return to IDLE.
  - No wrap: no beat is accepted past 2047.
- RUN:
  - smp_en=1 every cycle.
  - cyc counts 0..FRAME_CYCLES-1 and wraps; frm increments on each cyc wrap, 0..FRAMES-1.
  - da_start=1 exactly when cyc==0.
  - da_reset=1 exactly when cyc==0 && frm==0.
  - da_cload=0 and da_valid_in=0 throughout.
- Result capture:
  - When cyc==11 && frm==15, da_acc_out is latched into res_data and res_valid=1 on the next edge.
  - res_valid holds until res_valid && res_ready.
  - If a new capture coincides with a pending unaccepted result, res_data is overwritten, res_valid stays 1, and overrun is set (cleared only by reset).
  - Acceptance and capture in the same cycle: new result is valid, overrun is not set.
- Stopping: when run_en is low at cyc==11 && frm==15, return to IDLE after that capture. Mid-group deassertion does not truncate the group.
- Latency:
  - First da_start occurs 1 cycle after run_en is sampled in IDLE.
  - First res_valid occurs 192 cycles after the first da_start.
- Coefficient values pass through bit-exact (two's complement); no arithmetic in this block.

Test Plan:
- Reset mid-LOAD at beat 700 → all outputs 0 immediately, loaded=0; a subsequent full 2048-beat load is accepted with da_caddr 0..2047.
- Load 2048 beats with cfg_valid toggled every other cycle → da_cload high only on beat cycles; da_cin matches input; load_done pulses once; beat 2049 is not accepted.
- run_en=1 after load → da_start every 12 cycles; da_reset on starts #1, #17, #33; smp_en continuous.
- Drive da_acc_out = -5 at the capture cycle, res_ready=1 → res_valid for one cycle with res_data = 39'h7F_FFFF_FFFB; overrun=0.
- res_ready=0 across two groups → second capture overwrites res_data and overrun=1; res_ready asserted on the capture cycle instead → overrun stays 0.
- run_en dropped at frame 5 → group completes, result delivered, busy=0 on the cycle after capture; load_req during RUN ignored.
